// File: rtl/serial_pkg.sv
// Shared types and constants for the serial word transmit path.
package serial_pkg;

   localparam int WORD_W = 24;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      GAP
   } tx_state_t;

endpackage

// File: rtl/serial_word_tx.sv
// Serial word transmitter: accepts a parallel word on valid/ready and shifts it
// out MSB-first on b1t with a frame strobe, followed by a fixed idle gap.
module serial_word_tx
   import serial_pkg::WORD_W;
   import serial_pkg::tx_state_t;
#(
   parameter int N   = WORD_W,
   parameter int GAP = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] data_i,
   input  logic         valid_i,
   output logic         ready_o,
   output logic         b1t,
   output logic         frame_o
);

   localparam int CW = $clog2(N);
   localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
   localparam logic [GW-1:0] GAP_LOAD = (GAP > 0) ? GW'(GAP - 1) : '0;

   // The GAP parameter shadows the package state literal, so states are qualified.
   tx_state_t     state_q, state_d;
   logic [N-1:0]  sr_q, sr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [GW-1:0] gcnt_q, gcnt_d;
   logic          b1t_d, frame_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= serial_pkg::IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         serial_pkg::IDLE: begin
            if (valid_i) state_d = serial_pkg::SHIFT;
         end
         serial_pkg::SHIFT: begin
            if (cnt_q == '0) begin
               if (GAP > 0) state_d = serial_pkg::GAP;
               else         state_d = serial_pkg::IDLE;
            end
         end
         serial_pkg::GAP: begin
            if (gcnt_q == '0) state_d = serial_pkg::IDLE;
         end
         default: state_d = serial_pkg::IDLE;
      endcase
   end

   // The MSB is driven on the accept edge itself, so cnt counts the bits still
   // to follow the one currently on the line.
   always_comb begin
      ready_o = (state_q == serial_pkg::IDLE);
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      gcnt_d  = gcnt_q;
      b1t_d   = 1'b0;
      frame_d = 1'b0;
      unique case (state_q)
         serial_pkg::IDLE: begin
            if (valid_i) begin
               sr_d    = {data_i[N-2:0], 1'b0};
               b1t_d   = data_i[N-1];
               frame_d = 1'b1;
               cnt_d   = CNT_LAST;
            end
         end
         serial_pkg::SHIFT: begin
            if (cnt_q != '0) begin
               sr_d    = {sr_q[N-2:0], 1'b0};
               b1t_d   = sr_q[N-1];
               frame_d = 1'b1;
               cnt_d   = cnt_q - CW'(1);
            end else begin
               gcnt_d  = GAP_LOAD;
            end
         end
         serial_pkg::GAP: begin
            if (gcnt_q != '0) gcnt_d = gcnt_q - GW'(1);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sr_q    <= '0;
         cnt_q   <= '0;
         gcnt_q  <= '0;
         b1t     <= 1'b0;
         frame_o <= 1'b0;
      end else begin
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
         gcnt_q  <= gcnt_d;
         b1t     <= b1t_d;
         frame_o <= frame_d;
      end
   end

endmodule
